motor_bridge_seq: RTL and testbench

H-bridge sequencer that turns the direction flags from the line-follow direction FSM (`right`, `left`) into the four gate drives of one DC-motor H-bridge. It does three things:
- Generates the speed PWM.
- Inserts a programmable dead-time whenever the drive leaves a conducting state, so no bridge leg ever shoots through.
- Optionally brakes the motor when both flags are set.

It sits between the direction FSM and the chip output pins.

---
 rtl/motor_bridge_seq.sv | 148 ++++++++++++++
 tb/tb_motor_bridge_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/motor_bridge_seq.sv
// motor_bridge_seq
//   H-bridge sequencer for one DC motor. Turns the direction flags from the
//   line-follow FSM into four gate drives, with a speed PWM on the active high
//   side and a programmable dead-time whenever a conducting state is left.
//
//   Optional feature macro: MOTOR_BRAKE_EN
//     defined   -> request 11 selects BRAKE (both low sides on)
//     undefined -> request 11 decodes as COAST; BRAKE is unreachable
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset (deassertion synchronized)
//   right    in   request forward drive
//   left     in   request reverse drive
//   duty     in   PWM duty, high time = duty counts of 2^CNT_W
//   a_hi     out  leg A high-side gate (registered)
//   a_lo     out  leg A low-side gate  (registered)
//   b_hi     out  leg B high-side gate (registered)
//   b_lo     out  leg B low-side gate  (registered)
//   busy     out  high while in DEAD
//   state_o  out  state encoding: COAST=0 FWD=1 REV=2 DEAD=3 BRAKE=4

module motor_bridge_seq #(
    parameter int CNT_W       = 8,
    parameter int DEAD_CYCLES = 16,
    parameter int DEAD_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             right,
    input  logic             left,
    input  logic [CNT_W-1:0] duty,
    output logic             a_hi,
    output logic             a_lo,
    output logic             b_hi,
    output logic             b_lo,
    output logic             busy,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        COAST = 3'd0,
        FWD   = 3'd1,
        REV   = 3'd2,
        DEAD  = 3'd3,
        BRAKE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES - 1);

    state_t              state;
    state_t              target;
    logic                run;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    duty_q;
    logic [DEAD_W-1:0]   dead_cnt;
    logic                pwm_on;

    // Reset release is taken through one flop so state can first move on the
    // second rising edge after rst goes high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    always_comb begin
        target = COAST;
        case ({right, left})
            2'b10:   target = FWD;
            2'b01:   target = REV;
`ifdef MOTOR_BRAKE_EN
            2'b11:   target = BRAKE;
`else
            2'b11:   target = COAST;
`endif
            default: target = COAST;
        endcase
    end

    // Duty is captured only on the last count of a period so a change never
    // truncates or stretches the pulse already in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            duty_q <= '0;
        end else if (run) begin
            if (cnt == CNT_MAX) begin
                duty_q <= duty;
            end
            cnt <= cnt + 1'b1;
        end
    end

    assign pwm_on = (cnt < duty_q);

    // Gates are decoded from the current (pre-edge) state, so they trail the
    // state register by one cycle. Leaving a conducting state therefore always
    // shows one extra zero-gate cycle after DEAD, never an overlap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= COAST;
            dead_cnt <= '0;
            a_hi     <= 1'b0;
            a_lo     <= 1'b0;
            b_hi     <= 1'b0;
            b_lo     <= 1'b0;
        end else begin
            a_hi <= (state == FWD) && pwm_on;
            a_lo <= (state == REV) || (state == BRAKE);
            b_hi <= (state == REV) && pwm_on;
            b_lo <= (state == FWD) || (state == BRAKE);

            if (run) begin
                case (state)
                    COAST: begin
                        state <= target;
                    end
                    FWD, REV, BRAKE: begin
                        if (target != state) begin
                            state    <= DEAD;
                            dead_cnt <= DEAD_LOAD;
                        end
                    end
                    DEAD: begin
                        // Exit goes to whatever is requested on the final
                        // dead cycle, not the request that caused entry.
                        if (dead_cnt == '0) begin
                            state <= target;
                        end else begin
                            dead_cnt <= dead_cnt - 1'b1;
                        end
                    end
                    default: begin
                        state <= COAST;
                    end
                endcase
            end
        end
    end

    assign busy    = (state == DEAD);
    assign state_o = state;

endmodule

// File: tb/tb_motor_bridge_seq.sv
module tb_motor_bridge_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       right;
    logic       left;
    logic [7:0] duty;
    logic       a_hi, a_lo, b_hi, b_lo, busy;
    logic [2:0] state_o;
    logic [3:0] gates;

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;

    always #5 clk = ~clk;

    assign gates = {a_hi, a_lo, b_hi, b_lo};

    motor_bridge_seq #(
        .CNT_W      (8),
        .DEAD_CYCLES(16),
        .DEAD_W     (5)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .right  (right),
        .left   (left),
        .duty   (duty),
        .a_hi   (a_hi),
        .a_lo   (a_lo),
        .b_hi   (b_hi),
        .b_lo   (b_lo),
        .busy   (busy),
        .state_o(state_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // No leg may ever have both of its switches on.
    always @(negedge clk) begin
        if (mon_en) begin
            check("shoot_through", 32'((a_hi & a_lo) | (b_hi & b_lo)), 32'd0);
        end
    end

    // Count high samples of a_hi (sel=0) or b_hi (sel=1) over n cycles.
    task automatic count_gate(input int sel, input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sel == 0) c += int'(a_hi);
            else          c += int'(b_hi);
        end
    endtask

    // Observe 20 cycles after a request that enters DEAD. Optionally clear the
    // request right after sampling cycle retarget_at.
    task automatic run_dead(input int retarget_at, output int busy_n, output int gz_n,
                            output logic [2:0] st6, output logic [2:0] st16,
                            output logic [3:0] g17);
        busy_n = 0;
        gz_n   = 0;
        st6    = '0;
        st16   = '0;
        g17    = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            busy_n += int'(busy);
            if (i >= 1 && i <= 16 && gates == 4'b0000) gz_n++;
            if (i == 6)  st6  = state_o;
            if (i == 16) st16 = state_o;
            if (i == 17) g17  = gates;
            if (i == retarget_at) begin
                right = 1'b0;
                left  = 1'b0;
            end
        end
    endtask

    initial begin
        int         c;
        int         busy_n;
        int         gz_n;
        logic [2:0] st6;
        logic [2:0] st16;
        logic [3:0] g17;
        logic       prev;
        bit         found;

        rst   = 1'b1;
        right = 1'b1;
        left  = 1'b0;
        duty  = 8'd128;
        #1 rst = 1'b0;
        mon_en = 1'b1;

        // Reset with forward request pending
        repeat (3) @(negedge clk);
        check("rst_gates", 32'(gates), 32'd0);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        rst = 1'b1;
        @(negedge clk);
        check("release_sync_state", 32'(state_o), 32'd0);
        @(negedge clk);
        check("release_fwd_state", 32'(state_o), 32'd1);
        check("release_fwd_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("fwd_b_lo", 32'(b_lo), 32'd1);
        check("fwd_a_lo", 32'(a_lo), 32'd0);
        check("fwd_b_hi", 32'(b_hi), 32'd0);
        repeat (300) @(negedge clk);
        count_gate(0, 256, c);
        check("fwd_duty128_count", 32'(c), 32'd128);

        // Reversal FWD -> DEAD -> REV
        right = 1'b0;
        left  = 1'b1;
        run_dead(-1, busy_n, gz_n, st6, st16, g17);
        check("rev_busy_cycles", 32'(busy_n), 32'd16);
        check("rev_gates_zero_cycles", 32'(gz_n), 32'd16);
        check("rev_mid_state", 32'(st6), 32'd3);
        check("rev_exit_state", 32'(st16), 32'd2);
        check("rev_a_lo", 32'(g17[2]), 32'd1);
        check("rev_a_hi", 32'(g17[3]), 32'd0);
        check("rev_b_lo", 32'(g17[0]), 32'd0);
        count_gate(1, 256, c);
        check("rev_duty128_count", 32'(c), 32'd128);

        // Request FWD from REV, then drop to 00 at dead cycle 5
        right = 1'b1;
        left  = 1'b0;
        run_dead(5, busy_n, gz_n, st6, st16, g17);
        check("retarget_busy_cycles", 32'(busy_n), 32'd16);
        check("retarget_still_dead", 32'(st6), 32'd3);
        check("retarget_exit_coast", 32'(st16), 32'd0);
        check("retarget_gates", 32'(g17), 32'd0);

        // Duty reload 64 -> 200 at cnt=10
        duty  = 8'd64;
        right = 1'b1;
        left  = 1'b0;
        repeat (300) @(negedge clk);
        check("reload_fwd_state", 32'(state_o), 32'd1);
        prev  = a_hi;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (a_hi && !prev) found = 1'b1;
            prev = a_hi;
        end
        check("reload_found_period_start", 32'(found), 32'd1);
        // This sample reflects cnt=0; the live counter is now 1.
        c = int'(a_hi);
        for (int j = 1; j < 256; j++) begin
            @(negedge clk);
            c += int'(a_hi);
            if (j == 9) duty = 8'd200;
        end
        check("reload_old_period", 32'(c), 32'd64);
        count_gate(0, 256, c);
        check("reload_new_period", 32'(c), 32'd200);

        duty = 8'd0;
        repeat (300) @(negedge clk);
        count_gate(0, 256, c);
        check("duty0_count", 32'(c), 32'd0);

        duty = 8'd255;
        repeat (300) @(negedge clk);
        count_gate(0, 256, c);
        check("duty255_count", 32'(c), 32'd255);
        check("duty255_b_lo", 32'(b_lo), 32'd1);

        // Both flags from FWD
        right = 1'b1;
        left  = 1'b1;
        run_dead(-1, busy_n, gz_n, st6, st16, g17);
        check("both_busy_cycles", 32'(busy_n), 32'd16);
`ifdef MOTOR_BRAKE_EN
        check("both_state", 32'(st16), 32'd4);
        check("both_gates", 32'(g17), 32'b0101);
`else
        check("both_state", 32'(st16), 32'd0);
        check("both_gates", 32'(g17), 32'd0);
`endif

        right = 1'b1;
        left  = 1'b0;
        repeat (40) @(negedge clk);
        check("back_to_fwd", 32'(state_o), 32'd1);

        // Async reset at dead cycle 7
        right = 1'b0;
        left  = 1'b1;
        repeat (7) @(negedge clk);
        check("async_pre_busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_gates", 32'(gates), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_state", 32'(state_o), 32'd0);
        right = 1'b1;
        left  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("async_rel_sync_state", 32'(state_o), 32'd0);
        @(negedge clk);
        check("async_rel_fwd_state", 32'(state_o), 32'd1);
        check("async_rel_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("async_rel_b_lo", 32'(b_lo), 32'd1);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
